serial_reg_decoder: RTL

Parametrised successor to the 4-register serial APU register decoder. Receives 10-bit-class async-style frames on sdi, sampled on the sck rising edge. Each frame carries one 4-bit nibble, a phase bit and a register address. A low/high nibble pair to the same address commits one 8-bit register. Adds explicit framing FSM, pair checking, write strobe, error counter and async reset. Sits between the external serial host and the APU channel blocks.

---
 rtl/serial_reg_decoder.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/serial_reg_decoder.sv
// Serial register decoder: LSB-first start/payload/stop frames on sdi commit 8-bit registers
// from low/high nibble pairs. Define PARITY_EN to add an even-parity bit after the payload.
module serial_reg_decoder #(
    parameter int ADDR_W   = 3,
    parameter int NUM_REGS = 8
) (
    input  logic                    sck,
    input  logic                    rst,
    input  logic                    sdi,
    output logic [NUM_REGS*8-1:0]   regs,
    output logic                    wr_stb,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [7:0]              err_cnt,
    output logic                    busy
);

    localparam int PAYLOAD_W = ADDR_W + 5;
    localparam int CNT_W     = $clog2(PAYLOAD_W + 1);
    localparam logic [ADDR_W:0] NUM_REGS_EXT = (ADDR_W+1)'(NUM_REGS);

`ifdef PARITY_EN
    typedef enum logic [2:0] {ST_IDLE, ST_SHIFT, ST_PARITY, ST_STOP, ST_RESYNC} state_t;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_SHIFT, ST_STOP, ST_RESYNC} state_t;
`endif

    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic [PAYLOAD_W-1:0]   payload_reg, payload_next;
    logic [3:0]             hold_reg, hold_next;
    logic [ADDR_W-1:0]      hold_addr_reg, hold_addr_next;
    logic                   hold_valid_reg, hold_valid_next;
    logic [7:0]             regs_reg [NUM_REGS];
    logic [7:0]             regs_next [NUM_REGS];
    logic                   wr_stb_reg, wr_stb_next;
    logic [ADDR_W-1:0]      wr_addr_reg, wr_addr_next;
    logic [7:0]             err_cnt_reg, err_cnt_next;
    logic                   err_inc;
    logic                   commit;
`ifdef PARITY_EN
    logic                   parity_reg, parity_next;
`endif

    logic [3:0]             frame_data;
    logic                   frame_phase;
    logic [ADDR_W-1:0]      frame_addr;

    assign frame_data  = payload_reg[3:0];
    assign frame_phase = payload_reg[4];
    assign frame_addr  = payload_reg[PAYLOAD_W-1:5];

    always_ff @(posedge sck or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            payload_reg    <= '0;
            hold_reg       <= '0;
            hold_addr_reg  <= '0;
            hold_valid_reg <= 1'b0;
            regs_reg       <= '{default: '0};
            wr_stb_reg     <= 1'b0;
            wr_addr_reg    <= '0;
            err_cnt_reg    <= '0;
`ifdef PARITY_EN
            parity_reg     <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            payload_reg    <= payload_next;
            hold_reg       <= hold_next;
            hold_addr_reg  <= hold_addr_next;
            hold_valid_reg <= hold_valid_next;
            regs_reg       <= regs_next;
            wr_stb_reg     <= wr_stb_next;
            wr_addr_reg    <= wr_addr_next;
            err_cnt_reg    <= err_cnt_next;
`ifdef PARITY_EN
            parity_reg     <= parity_next;
`endif
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        payload_next    = payload_reg;
        hold_next       = hold_reg;
        hold_addr_next  = hold_addr_reg;
        hold_valid_next = hold_valid_reg;
        regs_next       = regs_reg;
        wr_stb_next     = 1'b0;
        wr_addr_next    = wr_addr_reg;
        err_inc         = 1'b0;
        commit          = 1'b0;
`ifdef PARITY_EN
        parity_next     = parity_reg;
`endif

        case (state_reg)
            ST_IDLE: begin
                if (!sdi) begin
                    state_next = ST_SHIFT;
                    cnt_next   = CNT_W'(PAYLOAD_W);
                end
            end
            ST_SHIFT: begin
                payload_next = {sdi, payload_reg[PAYLOAD_W-1:1]};
                cnt_next     = cnt_reg - CNT_W'(1);
                if (cnt_reg == CNT_W'(1)) begin
`ifdef PARITY_EN
                    state_next = ST_PARITY;
`else
                    state_next = ST_STOP;
`endif
                end
            end
`ifdef PARITY_EN
            ST_PARITY: begin
                parity_next = sdi;
                state_next  = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (sdi) begin
                    state_next = ST_IDLE;
`ifdef PARITY_EN
                    if (^{payload_reg, parity_reg}) begin
                        err_inc         = 1'b1;
                        hold_valid_next = 1'b0;
                    end else
`endif
                    if (!frame_phase) begin
                        hold_next       = frame_data;
                        hold_addr_next  = frame_addr;
                        hold_valid_next = 1'b1;
                    end else begin
                        hold_valid_next = 1'b0;
                        if (hold_valid_reg && hold_addr_reg == frame_addr) begin
                            // Matched pairs beyond the register file are dropped quietly
                            if ({1'b0, frame_addr} < NUM_REGS_EXT) begin
                                commit       = 1'b1;
                                wr_stb_next  = 1'b1;
                                wr_addr_next = frame_addr;
                            end
                        end else begin
                            err_inc = 1'b1;
                        end
                    end
                end else begin
                    err_inc         = 1'b1;
                    hold_valid_next = 1'b0;
                    state_next      = ST_RESYNC;
                end
            end
            ST_RESYNC: begin
                if (sdi) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        for (int k = 0; k < NUM_REGS; k++) begin
            if (commit && frame_addr == ADDR_W'(k)) begin
                regs_next[k] = {frame_data, hold_reg};
            end
        end

        err_cnt_next = err_cnt_reg;
        if (err_inc && err_cnt_reg != 8'hFF) begin
            err_cnt_next = err_cnt_reg + 8'd1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_regs_out
            assign regs[8*gi +: 8] = regs_reg[gi];
        end
    endgenerate

    assign wr_stb  = wr_stb_reg;
    assign wr_addr = wr_addr_reg;
    assign err_cnt = err_cnt_reg;
    assign busy    = (state_reg != ST_IDLE);

endmodule
